// File: rtl/path_writer_pkg.sv
// Constants and state encoding shared by path_writer and the Dijkstra engine.
package path_writer_pkg;

    localparam int DEFAULT_MAX_NODES   = 16;
    localparam int DEFAULT_INDEX_WIDTH = 4;
    localparam int DEFAULT_MADDR_WIDTH = 8;
    localparam int DEFAULT_MDATA_WIDTH = 8;

    // Predecessor marker for "no predecessor"; instances slice it to INDEX_WIDTH bits.
    localparam logic [31:0] NO_PREVIOUS_NODE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WALK       = 3'd1,
        WRITE_LEN  = 3'd2,
        WRITE_NODE = 3'd3,
        DONE       = 3'd4
    } pw_state_t;

endpackage

// File: rtl/path_stack.sv
// Node stack for path_writer: entry 0 loaded on init, append on push, indexed read.
module path_stack #(
    parameter int MAX_NODES   = 16,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   init,
    input  logic                   push,
    input  logic [INDEX_WIDTH-1:0] wr_data,
    input  logic [INDEX_WIDTH-1:0] rd_addr,
    output logic [INDEX_WIDTH-1:0] rd_data,
    output logic [INDEX_WIDTH-1:0] count
);

    logic [INDEX_WIDTH-1:0] mem_r [MAX_NODES];
    logic [INDEX_WIDTH-1:0] count_r;

    // Storage and fill count; pushes beyond the depth are dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= '0;
        end else if (init) begin
            mem_r[0] <= wr_data;
            count_r  <= INDEX_WIDTH'(1);
        end else if (push && (int'(count_r) < MAX_NODES)) begin
            mem_r[count_r] <= wr_data;
            count_r        <= count_r + INDEX_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign rd_data = mem_r[rd_addr];
    assign count   = count_r;

endmodule

// File: rtl/path_writer.sv
// Walks prev_vector from destination back to source, then writes the length word
// followed by the path (source first) through a valid/ready memory write port.
module path_writer
    import path_writer_pkg::*;
#(
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [INDEX_WIDTH-1:0]                source,
    input  logic [INDEX_WIDTH-1:0]                destination,
    input  logic [INDEX_WIDTH-1:0]                number_of_nodes,
    input  logic [MADDR_WIDTH-1:0]                out_base_address,
    input  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] prev_vector,
    output logic                                  mem_write_enable,
    input  logic                                  mem_write_ready,
    output logic [MADDR_WIDTH-1:0]                mem_addr,
    output logic [MDATA_WIDTH-1:0]                mem_write_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  no_path,
    output logic [INDEX_WIDTH-1:0]                path_length
);

    localparam logic [INDEX_WIDTH-1:0] NO_PREV = NO_PREVIOUS_NODE[INDEX_WIDTH-1:0];

    pw_state_t              state_r;
    logic [INDEX_WIDTH-1:0] src_r, nodes_r, cur_r, len_r, k_r;
    logic [MADDR_WIDTH-1:0] base_r, addr_r;
    logic [MDATA_WIDTH-1:0] data_r;
    logic                   en_r, busy_r, done_r, no_path_r;

    logic                   st_init_s, st_push_s, walk_bad_s;
    logic [INDEX_WIDTH-1:0] st_wdata_s, st_raddr_s, st_rdata_s, st_count_s, p_s;

    path_stack #(.MAX_NODES(MAX_NODES), .INDEX_WIDTH(INDEX_WIDTH)) u_stack (
        .clock   (clock),
        .reset   (reset),
        .init    (st_init_s),
        .push    (st_push_s),
        .wr_data (st_wdata_s),
        .rd_addr (st_raddr_s),
        .rd_data (st_rdata_s),
        .count   (st_count_s)
    );

    assign p_s        = prev_vector[cur_r];
    assign walk_bad_s = (p_s == NO_PREV) || (p_s >= nodes_r) || (st_count_s == nodes_r);
    // Stack slot of the word after the one being presented (k_r is 0 during WRITE_LEN).
    assign st_raddr_s = len_r - k_r - INDEX_WIDTH'(1);

    // Stack load/push requests derived from the current state.
    always_comb begin
        st_init_s  = 1'b0;
        st_push_s  = 1'b0;
        st_wdata_s = '0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    st_init_s  = 1'b1;
                    st_wdata_s = destination;
                end else begin
                    st_init_s = 1'b0;
                end
            end
            WALK: begin
                if ((cur_r != src_r) && !walk_bad_s) begin
                    st_push_s  = 1'b1;
                    st_wdata_s = p_s;
                end else begin
                    st_push_s = 1'b0;
                end
            end
            default: begin
                st_init_s = 1'b0;
            end
        endcase
    end

    // Control FSM with registered write port and status outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= IDLE;
            src_r     <= '0;
            nodes_r   <= '0;
            cur_r     <= '0;
            len_r     <= '0;
            k_r       <= '0;
            base_r    <= '0;
            addr_r    <= '0;
            data_r    <= '0;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            no_path_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        src_r     <= source;
                        nodes_r   <= number_of_nodes;
                        base_r    <= out_base_address;
                        cur_r     <= destination;
                        k_r       <= '0;
                        len_r     <= '0;
                        done_r    <= 1'b0;
                        no_path_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= WALK;
                    end else begin
                        state_r <= state_r;
                    end
                end
                WALK: begin
                    if (cur_r == src_r) begin
                        len_r   <= st_count_s;
                        addr_r  <= base_r;
                        data_r  <= MDATA_WIDTH'(st_count_s);
                        en_r    <= 1'b1;
                        state_r <= WRITE_LEN;
                    end else if (walk_bad_s) begin
                        no_path_r <= 1'b1;
                        len_r     <= '0;
                        addr_r    <= base_r;
                        data_r    <= '0;
                        en_r      <= 1'b1;
                        state_r   <= WRITE_LEN;
                    end else begin
                        cur_r <= p_s;
                    end
                end
                WRITE_LEN, WRITE_NODE: begin
                    if (mem_write_ready) begin
                        if (no_path_r || ((state_r == WRITE_NODE) && (k_r == len_r))) begin
                            en_r    <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            k_r     <= k_r + INDEX_WIDTH'(1);
                            addr_r  <= addr_r + MADDR_WIDTH'(1);
                            data_r  <= MDATA_WIDTH'(st_rdata_s);
                            state_r <= WRITE_NODE;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    en_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_write_enable = en_r;
    assign mem_addr         = addr_r;
    assign mem_write_data   = data_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign no_path          = no_path_r;
    assign path_length      = len_r;

endmodule

// File: tb/tb_path_writer.sv
// Self-checking bench for path_writer: directed table, hand sequences, random trees.
module tb_path_writer;
    localparam int MN = 16;
    localparam int IW = 4;
    localparam int MA = 8;
    localparam int MD = 8;

    logic                   clock = 1'b0;
    logic                   reset, start, mem_write_ready;
    logic [IW-1:0]          source, destination, number_of_nodes;
    logic [MA-1:0]          out_base_address;
    logic [MN-1:0][IW-1:0]  prev_vector;
    logic                   mem_write_enable, busy, done, no_path;
    logic [MA-1:0]          mem_addr;
    logic [MD-1:0]          mem_write_data;
    logic [IW-1:0]          path_length;

    path_writer #(.MAX_NODES(MN), .INDEX_WIDTH(IW), .MADDR_WIDTH(MA), .MDATA_WIDTH(MD)) dut (
        .clock(clock), .reset(reset), .start(start), .source(source),
        .destination(destination), .number_of_nodes(number_of_nodes),
        .out_base_address(out_base_address), .prev_vector(prev_vector),
        .mem_write_enable(mem_write_enable), .mem_write_ready(mem_write_ready),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .busy(busy),
        .done(done), .no_path(no_path), .path_length(path_length)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: follow predecessors from destination, give up on absent/out-of-range
    // links or once the chain already holds number_of_nodes entries.
    int m_len, m_steps;
    bit m_nopath;
    int m_nodes[$];

    task automatic model(input int src, input int dst, input int n);
        int chain[$];
        int cur, p;
        chain.push_back(dst);
        cur = dst;
        m_nopath = 1'b0;
        forever begin
            if (cur == src) break;
            p = int'(prev_vector[cur]);
            if (p == 15 || p >= n || chain.size() == n) begin
                m_nopath = 1'b1;
                break;
            end
            chain.push_back(p);
            cur = p;
        end
        m_steps = chain.size();
        m_len = m_nopath ? 0 : chain.size();
        m_nodes = {};
        if (!m_nopath) for (int i = chain.size() - 1; i >= 0; i--) m_nodes.push_back(chain[i]);
    endtask

    task automatic set_prev(input int pv);
        for (int i = 0; i < MN; i++) prev_vector[i] = 4'hF;
        case (pv)
            1: begin prev_vector[5] = 4'd2; prev_vector[2] = 4'd0; end
            3: begin prev_vector[1] = 4'd2; prev_vector[2] = 4'd1; end
            4: begin prev_vector[5] = 4'd9; end
            default: ;
        endcase
    endtask

    // One full run: start, latency, write capture with stall checks, final status.
    task automatic run(input string tag, input int src, input int dst, input int n, input int base,
                       input int ready_mode, input bit poke, input int exp_len, input int exp_np);
        logic [MA-1:0] wa[$];
        logic [MD-1:0] wd[$];
        logic [MA-1:0] hold_a, a_exp;
        logic [MD-1:0] hold_d;
        bit stalled, rdy;
        int lat, cyc;
        model(src, dst, n);
        @(negedge clock);
        source = IW'(src); destination = IW'(dst); number_of_nodes = IW'(n);
        out_base_address = MA'(base); mem_write_ready = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!mem_write_enable && lat < 100) begin
            start = (poke && lat == 1);
            destination = (poke && lat == 1) ? IW'(dst + 1) : IW'(dst);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        destination = IW'(dst);
        check({tag, "_latency"}, lat, m_steps + 1);
        cyc = 0; stalled = 1'b0; hold_a = '0; hold_d = '0;
        while (!done && cyc < 300) begin
            if (stalled) begin
                check({tag, "_stall_en"}, mem_write_enable, 1);
                check({tag, "_stall_addr"}, mem_addr, hold_a);
                check({tag, "_stall_data"}, mem_write_data, hold_d);
            end
            rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_write_ready = rdy;
            if (mem_write_enable) begin
                hold_a = mem_addr; hold_d = mem_write_data;
                stalled = !rdy;
                if (rdy) begin wa.push_back(mem_addr); wd.push_back(mem_write_data); end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        mem_write_ready = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_en_off"}, mem_write_enable, 0);
        check({tag, "_no_path"}, no_path, exp_np);
        check({tag, "_length"}, path_length, exp_len);
        check({tag, "_nwrites"}, wa.size(), m_len + 1);
        if (ready_mode == 0) check({tag, "_back_to_back"}, cyc, m_len + 1);
        for (int k = 0; k < wa.size() && k <= m_len; k++) begin
            a_exp = MA'(base + k);
            check({tag, "_addr"}, wa[k], a_exp);
            check({tag, "_data"}, wd[k], (k == 0) ? m_len : m_nodes[k-1]);
        end
    endtask

    typedef struct {
        int pv; int src; int dst; int n; int base; int mode; bit poke; int len; int np;
    } vec_t;
    vec_t vecs[8];

    task automatic check_zero(input string tag);
        check({tag, "_en"}, mem_write_enable, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_data"}, mem_write_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_no_path"}, no_path, 0);
        check({tag, "_len"}, path_length, 0);
    endtask

    initial begin
        int w;
        int rn, rs, rd;
        reset = 1'b0; start = 1'b0; mem_write_ready = 1'b0;
        source = '0; destination = '0; number_of_nodes = '0; out_base_address = '0;
        set_prev(0);
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;

        vecs[0] = '{pv:1, src:0, dst:5, n:8, base:'h40, mode:0, poke:0, len:3, np:0};
        vecs[1] = '{pv:1, src:0, dst:5, n:8, base:'h40, mode:1, poke:0, len:3, np:0};
        vecs[2] = '{pv:2, src:0, dst:5, n:8, base:'h40, mode:0, poke:0, len:0, np:1};
        vecs[3] = '{pv:3, src:0, dst:1, n:4, base:'h40, mode:0, poke:0, len:0, np:1};
        vecs[4] = '{pv:1, src:3, dst:3, n:8, base:'h40, mode:0, poke:0, len:1, np:0};
        vecs[5] = '{pv:1, src:0, dst:5, n:8, base:'hFE, mode:1, poke:1, len:3, np:0};
        vecs[6] = '{pv:4, src:0, dst:5, n:8, base:'h40, mode:0, poke:0, len:0, np:1};
        vecs[7] = '{pv:1, src:2, dst:5, n:8, base:'h10, mode:0, poke:1, len:2, np:0};
        for (int i = 0; i < 8; i++) begin
            set_prev(vecs[i].pv);
            run($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].base,
                vecs[i].mode, vecs[i].poke, vecs[i].len, vecs[i].np);
        end

        // Reset while the length word of a src==dst run is stalled.
        set_prev(1);
        @(negedge clock);
        source = 4'd3; destination = 4'd3; number_of_nodes = 4'd8;
        out_base_address = 8'h40; mem_write_ready = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        w = 0;
        while (!mem_write_enable && w < 50) begin @(negedge clock); w++; end
        check("midwrite_en_seen", mem_write_enable, 1);
        reset = 1'b0;
        @(negedge clock);
        check_zero("midreset");
        reset = 1'b1;
        run("after_reset", 0, 5, 8, 'h40, 1, 0, 3, 0);

        // Random predecessor forests, mostly rooted at node 0.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < MN; i++) begin
                if (i == 0) prev_vector[i] = 4'hF;
                else if ($urandom_range(0, 4) == 0) prev_vector[i] = IW'($urandom_range(0, 15));
                else prev_vector[i] = IW'($urandom_range(0, i - 1));
            end
            rn = $urandom_range(2, 15);
            rs = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rn - 1) : 0;
            rd = $urandom_range(0, rn - 1);
            model(rs, rd, rn);
            run($sformatf("rand%0d", it), rs, rd, rn, $urandom_range(0, 255),
                $urandom_range(0, 1), 1'($urandom_range(0, 1)), m_len, m_nopath);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
